adc_serial_reader: RTL
======================

Name: adc_serial_reader

Overview:
- Serial-ADC readout stage of the logger front end; sits between the ADC pins (nDRDY, SDIN1, SCLK1) and the sample sink in main.
- Waits for the ADC data-ready pulse, generates SCLK1 and shifts in one MSB-first word.
- Presents the word as a parallel sample with a one-cycle valid strobe.
- Flags data-ready events that arrive during a readout.

Parameters:
- BITS, 16, bits per ADC word (2..32).
- SCLK_HALF, 8, clk cycles per SCLK1 half-period (≥4, so the ADC has time to shift after a falling edge).

Ports:
- clk  in  1  system clock (25 MHz in the bench).
- res  in  1  reset; synchronous to clk, active-high.
- enable  in  1  1 = accept data-ready events; 0 = ignore new events (an active readout still completes).
- nDRDY  in  1  ADC data-ready pulse, asynchronous to clk.
- SDIN1  in  1  ADC serial data; ADC updates it after each SCLK1 falling edge.
- SCLK1  out  1  serial clock to the ADC; idles low.
- sample_data  out  BITS  last completed word, MSB = first bit received.
- sample_valid  out  1  one-cycle strobe when sample_data updates.
- busy  out  1  high while a readout is in progress.
- overrun  out  1  sticky; set by a data-ready event while busy.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (synchronous, res=1 at a clk edge):
  - SCLK1=0, sample_data=0, sample_valid=0, busy=0, overrun=0.
  - Synchronizer flops cleared; state=IDLE.
  - A reset mid-readout aborts it: no valid strobe, partial word discarded, SCLK1 low on the next cycle.
- Input conditioning:
  - nDRDY and SDIN1 each pass through 2 flops.
  - The data-ready event (drdy_ev) is the falling edge of the synchronized nDRDY, i.e. the end of the ready pulse; it is one cycle wide.
- States:
  - IDLE: SCLK1=0, busy=0. On drdy_ev & enable, clear bit counter and phase counter, go to LOW.
  - LOW: SCLK1=0 for SCLK_HALF cycles, then go to HIGH.
  - HIGH: SCLK1=1 for SCLK_HALF cycles. On the last HIGH cycle:
    - shift synchronized SDIN1 into the LSB of the shift register (shift left);
    - increment the bit counter;
    - SCLK1 goes 0 on the next cycle.
    - If bit counter = BITS-1 go to DONE, else go to LOW.
  - DONE (one cycle): sample_data <= shift register; sample_valid=1; busy=0; next state IDLE.
- busy is 1 in LOW and HIGH; its first cycle is the cycle after drdy_ev.
- Latency and pulses:
  - drdy_ev to sample_valid = 2·SCLK_HALF·BITS + 1 cycles (257 at defaults).
  - Exactly BITS SCLK1 pulses per readout, each high for exactly SCLK_HALF cycles.
- Overrun:
  - drdy_ev while busy sets overrun and does not restart the readout.
  - drdy_ev in the DONE cycle is also an overrun.
  - overrun_clr has priority over a same-cycle set.
- enable:
  - drdy_ev with enable=0 in IDLE is ignored and sets no flag.
  - Dropping enable mid-readout does not abort it.
- sample_data holds its value between strobes; it does not change during a readout.

Decomposition:
- Package adc_reader_pkg:
  - state enum IDLE/LOW/HIGH/DONE;
  - default BITS, SCLK_HALF;
  - counter width constants, clog2(BITS) and clog2(SCLK_HALF).
- Sub-module sync_edge: 2-flop synchronizer plus rise/fall pulse outputs; instantiated for nDRDY, and its synchronized output reused for SDIN1.
- Shift register, counters and FSM live in adc_serial_reader.

Test Plan:
- Reset then idle: hold res 2 cycles, nDRDY=0 for 1000 cycles -> SCLK1 stays 0, busy=0, sample_valid never asserts, all outputs 0.
- Single word: bench ADC model preloaded 0xA5C3 shifts MSB out on SCLK1 falling edges, one nDRDY high pulse of 250 ns -> 16 SCLK1 pulses, each high 8 cycles; one sample_valid; sample_data=0xA5C3; valid 257 cycles after drdy_ev.
- Periodic counter stream: nDRDY pulse every 31 µs, model loads its pulse count on the nDRDY rise -> successive samples 0x0000, 0x0001, 0x0002; overrun stays 0.
- Overrun: second nDRDY pulse issued 100 cycles into a readout -> first word still correct; no extra SCLK1 pulses; overrun=1 until overrun_clr pulse, then 0.
- Reset mid-readout: assert res after 5 SCLK1 pulses -> SCLK1=0 next cycle, no sample_valid, sample_data=0; the next nDRDY pulse reads a full correct word.
- enable gating: enable=0 during an nDRDY pulse -> no SCLK1 activity, overrun=0. enable=1 then dropped to 0 mid-readout -> word completes and valid asserts.

Source files
------------

// File: rtl/adc_reader_pkg.sv
// Shared types and sizing constants for the serial ADC readout stage.
// Holds the FSM state encoding, default word/clock geometry and counter widths.
package adc_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_BITS      = 16;
    localparam int DEF_SCLK_HALF = 8;

    // A counter for n values needs clog2(n) bits, but never fewer than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_BIT_CNT_W   = cnt_width(DEF_BITS);
    localparam int DEF_PHASE_CNT_W = cnt_width(DEF_SCLK_HALF);

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with one-cycle rise/fall
// pulses derived from the synchronized level.
module sync_edge
    import adc_reader_pkg::*;
(
    input  logic clk,
    input  logic res,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (res) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_q    = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/adc_serial_reader.sv
// Serial ADC readout: waits for the end of the data-ready pulse, clocks one
// MSB-first word in on SCLK1 and presents it with a one-cycle valid strobe.
module adc_serial_reader
    import adc_reader_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int SCLK_HALF = DEF_SCLK_HALF
) (
    input  logic            clk,
    input  logic            res,
    input  logic            enable,
    input  logic            nDRDY,
    input  logic            SDIN1,
    output logic            SCLK1,
    output logic [BITS-1:0] sample_data,
    output logic            sample_valid,
    output logic            busy,
    output logic            overrun,
    input  logic            overrun_clr
);

    localparam int BIT_W = cnt_width(BITS);
    localparam int PH_W  = cnt_width(SCLK_HALF);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCLK_HALF - 1);

    logic w_drdy_ev;
    logic w_drdy_rise;
    logic w_sdin;
    logic w_sdin_rise;
    logic w_sdin_fall;
    logic w_unused;

    state_t r_state;
    state_t w_state_next;
    logic   w_start;
    logic   w_shift_en;
    logic   w_phase_end;
    logic   w_counting;

    logic [PH_W-1:0]  r_phase;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BITS-1:0]  r_shift;
    logic [BITS-1:0]  r_sample_data;
    logic             r_sample_valid;
    logic             r_sclk;
    logic             r_busy;
    logic             r_overrun;

    sync_edge u_sync_drdy (
        .clk    (clk),
        .res    (res),
        .i_d    (nDRDY),
        .o_q    (),
        .o_rise (w_drdy_rise),
        .o_fall (w_drdy_ev)
    );

    sync_edge u_sync_sdin (
        .clk    (clk),
        .res    (res),
        .i_d    (SDIN1),
        .o_q    (w_sdin),
        .o_rise (w_sdin_rise),
        .o_fall (w_sdin_fall)
    );

    assign w_unused    = w_drdy_rise ^ w_sdin_rise ^ w_sdin_fall;
    assign w_counting  = (r_state == LOW) || (r_state == HIGH);
    assign w_phase_end = w_counting && (r_phase == PH_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; the bit is captured on the last HIGH cycle, just
    // before SCLK1 falls and the ADC moves to its next bit.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_drdy_ev && enable) begin
                    w_state_next = LOW;
                    w_start      = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            LOW: begin
                if (w_phase_end) begin
                    w_state_next = HIGH;
                end else begin
                    w_state_next = LOW;
                end
            end
            HIGH: begin
                if (w_phase_end) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = LOW;
                    end
                end else begin
                    w_state_next = HIGH;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Half-period and bit counters plus the input shift register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_phase   <= {PH_W{1'b0}};
            r_bit_cnt <= {BIT_W{1'b0}};
            r_shift   <= {BITS{1'b0}};
        end else begin
            if (w_counting && !w_phase_end) begin
                r_phase <= r_phase + PH_W'(1);
            end else begin
                r_phase <= {PH_W{1'b0}};
            end
            if (w_start) begin
                r_bit_cnt <= {BIT_W{1'b0}};
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (w_shift_en) begin
                r_shift <= {r_shift[BITS-2:0], w_sdin};
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (res) begin
            r_sclk         <= 1'b0;
            r_busy         <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_data  <= {BITS{1'b0}};
        end else begin
            r_sclk         <= (w_state_next == HIGH);
            r_busy         <= (w_state_next == LOW) || (w_state_next == HIGH);
            r_sample_valid <= w_shift_en && (w_state_next == DONE);
            if (w_shift_en && (w_state_next == DONE)) begin
                r_sample_data <= {r_shift[BITS-2:0], w_sdin};
            end
        end
    end

    // Sticky overrun: any data-ready event outside IDLE; clear wins over set.
    always_ff @(posedge clk) begin
        if (res) begin
            r_overrun <= 1'b0;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end else if (w_drdy_ev && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign SCLK1        = r_sclk;
    assign busy         = r_busy;
    assign sample_valid = r_sample_valid;
    assign sample_data  = r_sample_data;
    assign overrun      = r_overrun;

endmodule
